serial_crc_ccitt_checker: RTL and testbench

- Receive-side companion to the serial CRC-CCITT generator.
- Accepts a serial frame, MSB-first, one bit per enable strobe: a payload of frame_len bits followed by the 16-bit CRC, MSB first.
- Recomputes the CRC over the payload, compares it bit-by-bit with the received CRC, and reports pass/fail per frame.
- Sits after the serial deserialiser / line receiver, ahead of the frame buffer.

---
 rtl/serial_crc_pkg.sv | 23 ++
 rtl/serial_crc_ccitt_checker_lfsr.sv | 35 +++
 rtl/serial_crc_ccitt_checker.sv | 143 ++++++++++++++
 tb/tb_serial_crc_ccitt_checker.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/serial_crc_pkg.sv
// Shared CRC-CCITT definitions for the serial CRC generator/checker pair.
// Polynomial 0x1021, MSB-first, no reflection, no final XOR.
package serial_crc_pkg;

    localparam int unsigned      CRC_W    = 16;
    localparam logic [CRC_W-1:0] CRC_POLY = 16'h1021;
    localparam logic [CRC_W-1:0] CRC_INIT = 16'hFFFF;

    typedef enum logic [1:0] {
        StIdle,
        StPayload,
        StCrc,
        StDone
    } state_e;

    function automatic logic [CRC_W-1:0] crc_ccitt_step(input logic [CRC_W-1:0] lfsr,
                                                        input logic             din);
        logic fb;
        fb = din ^ lfsr[CRC_W-1];
        return {lfsr[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    endfunction

endpackage

// File: rtl/serial_crc_ccitt_checker_lfsr.sv
// 16-bit CRC-CCITT LFSR register: init_i restarts from INIT using the current bit,
// en_i alone advances one bit.
module crc_ccitt_lfsr
    import serial_crc_pkg::*;
#(
    parameter logic [CRC_W-1:0] INIT = CRC_INIT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en_i,
    input  logic             init_i,
    input  logic             data_i,
    output logic [CRC_W-1:0] lfsr_o
);

    logic [CRC_W-1:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en_i) begin
            lfsr_d = crc_ccitt_step(init_i ? INIT : lfsr_q, data_i);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q <= INIT;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/serial_crc_ccitt_checker.sv
// Serial CRC-CCITT frame checker: payload of frame_len bits then 16 CRC bits, MSB first.
// Optional SERIAL_CRC_CHECK_ERRCNT_EN adds a saturating err_count output.
module serial_crc_ccitt_checker
    import serial_crc_pkg::*;
#(
    parameter int unsigned      LEN_W = 16,
    parameter logic [CRC_W-1:0] INIT  = CRC_INIT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             sof,
    input  logic             data_in,
    input  logic [LEN_W-1:0] frame_len,
    output logic             busy,
    output logic             done,
    output logic             crc_ok,
    output logic             crc_err,
    output logic [CRC_W-1:0] crc_calc,
`ifdef SERIAL_CRC_CHECK_ERRCNT_EN
    output logic [CRC_W-1:0] crc_rx,
    output logic [15:0]      err_count
`else
    output logic [CRC_W-1:0] crc_rx
`endif
);

    // Counter must reach 16 in the CRC phase even for narrow LEN_W.
    localparam int unsigned CNT_W = (LEN_W > 5) ? LEN_W : 5;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             mism_q, busy_q, done_q, ok_q, err_q;
    logic [CRC_W-1:0] crc_calc_q, crc_rx_q;
    logic [CRC_W-1:0] lfsr;
    logic [3:0]       idx;
    logic             bit_mism, mism_next, start;

    assign start     = enable & sof;
    assign idx       = 4'(cnt_q - CNT_W'(1));
    assign bit_mism  = data_in ^ crc_calc_q[idx];
    assign mism_next = mism_q | bit_mism;

    crc_ccitt_lfsr #(
        .INIT(INIT)
    ) u_lfsr (
        .clk    (clk),
        .reset_n(reset_n),
        .en_i   (enable & (sof | (state_q == StPayload))),
        .init_i (sof),
        .data_i (data_in),
        .lfsr_o (lfsr)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            mism_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ok_q       <= 1'b0;
            err_q      <= 1'b0;
            crc_calc_q <= INIT;
            crc_rx_q   <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (start) begin
                // Any sof restarts, silently aborting a frame in progress.
                ok_q   <= 1'b0;
                busy_q <= 1'b1;
                mism_q <= 1'b0;
                crc_rx_q <= '0;
                if (frame_len == LEN_W'(0)) begin
                    crc_calc_q <= INIT;
                    crc_rx_q   <= {{(CRC_W-1){1'b0}}, data_in};
                    mism_q     <= data_in ^ INIT[CRC_W-1];
                    cnt_q      <= CNT_W'(15);
                    state_q    <= StCrc;
                end else if (frame_len == LEN_W'(1)) begin
                    crc_calc_q <= crc_ccitt_step(INIT, data_in);
                    cnt_q      <= CNT_W'(16);
                    state_q    <= StCrc;
                end else begin
                    cnt_q   <= CNT_W'(frame_len) - CNT_W'(1);
                    state_q <= StPayload;
                end
            end else begin
                unique case (state_q)
                    StIdle: ;
                    StPayload: begin
                        if (enable) begin
                            cnt_q <= cnt_q - CNT_W'(1);
                            if (cnt_q == CNT_W'(1)) begin
                                crc_calc_q <= crc_ccitt_step(lfsr, data_in);
                                cnt_q      <= CNT_W'(16);
                                state_q    <= StCrc;
                            end
                        end
                    end
                    StCrc: begin
                        if (enable) begin
                            crc_rx_q <= {crc_rx_q[CRC_W-2:0], data_in};
                            mism_q   <= mism_next;
                            cnt_q    <= cnt_q - CNT_W'(1);
                            if (cnt_q == CNT_W'(1)) begin
                                state_q <= StDone;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                ok_q    <= ~mism_next;
                                err_q   <= mism_next;
                            end
                        end
                    end
                    StDone: state_q <= StIdle;
                endcase
            end
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign crc_ok   = ok_q;
    assign crc_err  = err_q;
    assign crc_calc = crc_calc_q;
    assign crc_rx   = crc_rx_q;

`ifdef SERIAL_CRC_CHECK_ERRCNT_EN
    logic [15:0] err_count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_count_q <= '0;
        end else if (err_q && (err_count_q != 16'hFFFF)) begin
            err_count_q <= err_count_q + 16'd1;
        end
    end

    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_serial_crc_ccitt_checker.sv
// Directed bench for serial_crc_ccitt_checker using the "123456789" check vector (CRC 0x29B1).
module tb_serial_crc_ccitt_checker;

    localparam logic [71:0] PL = 72'h313233343536373839;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        enable = 1'b0;
    logic        sof = 1'b0;
    logic        data_in = 1'b0;
    logic [15:0] frame_len = 16'd0;
    logic        busy, done, crc_ok, crc_err;
    logic [15:0] crc_calc, crc_rx;
`ifdef SERIAL_CRC_CHECK_ERRCNT_EN
    logic [15:0] err_count;
`endif

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;

    serial_crc_ccitt_checker dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .sof      (sof),
        .data_in  (data_in),
        .frame_len(frame_len),
        .busy     (busy),
        .done     (done),
        .crc_ok   (crc_ok),
        .crc_err  (crc_err),
        .crc_calc (crc_calc),
`ifdef SERIAL_CRC_CHECK_ERRCNT_EN
        .crc_rx   (crc_rx),
        .err_count(err_count)
`else
        .crc_rx   (crc_rx)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Idle (with junk data) for gap cycles, then one strobe; returns at the following negedge.
    task automatic send_bit(input logic b, input logic s, input logic [15:0] len, input int gap);
        for (int i = 0; i < gap; i++) begin
            data_in = 1'($urandom);
            @(negedge clk);
        end
        enable = 1'b1;
        sof = s;
        data_in = b;
        frame_len = len;
        @(negedge clk);
        enable = 1'b0;
        sof = 1'b0;
    endtask

    task automatic send_frame(input logic [71:0] pl, input int len, input logic [15:0] crc,
                              input int maxgap);
        for (int i = 0; i < len + 16; i++) begin
            logic b;
            b = (i < len) ? pl[len-1-i] : crc[15-(i-len)];
            send_bit(b, i == 0, 16'(len), (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
            if (i == 0) begin
                check("busy_after_sof", {31'd0, busy}, 32'd1);
                check("ok_cleared_on_sof", {31'd0, crc_ok}, 32'd0);
            end
        end
    endtask

    task automatic check_result(input string tag, input logic ok, input logic [15:0] calc,
                                input logic [15:0] rx);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_ok"}, {31'd0, crc_ok}, {31'd0, ok});
        check({tag, "_err"}, {31'd0, crc_err}, {31'd0, ~ok});
        check({tag, "_calc"}, {16'd0, crc_calc}, {16'd0, calc});
        check({tag, "_rx"}, {16'd0, crc_rx}, {16'd0, rx});
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, "_err_pulse"}, {31'd0, crc_err}, 32'd0);
        check({tag, "_ok_held"}, {31'd0, crc_ok}, {31'd0, ok});
    endtask

    initial begin
        int d0;
        #1 reset_n = 1'b0;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_ok", {31'd0, crc_ok}, 32'd0);
        check("rst_err", {31'd0, crc_err}, 32'd0);
        check("rst_calc", {16'd0, crc_calc}, 32'h0000FFFF);
        check("rst_rx", {16'd0, crc_rx}, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Bit without sof in idle must be ignored.
        send_bit(1'b1, 1'b0, 16'd5, 0);
        check("idle_ignore_busy", {31'd0, busy}, 32'd0);

        send_frame(PL, 72, 16'h29B1, 0);
        check_result("good", 1'b1, 16'h29B1, 16'h29B1);

        send_frame(PL, 72, 16'h29B0, 0);
        check_result("bad", 1'b0, 16'h29B1, 16'h29B0);
`ifdef SERIAL_CRC_CHECK_ERRCNT_EN
        check("errcnt_1", {16'd0, err_count}, 32'd1);
`endif

        send_frame(PL, 0, 16'hFFFF, 0);
        check_result("len0_good", 1'b1, 16'hFFFF, 16'hFFFF);

        send_frame(PL, 0, 16'h7FFF, 0);
        check_result("len0_bad", 1'b0, 16'hFFFF, 16'h7FFF);
`ifdef SERIAL_CRC_CHECK_ERRCNT_EN
        check("errcnt_2", {16'd0, err_count}, 32'd2);
`endif

        d0 = done_cnt;
        send_frame(PL, 72, 16'h29B1, 5);
        check_result("gaps", 1'b1, 16'h29B1, 16'h29B1);
        @(negedge clk);
        check("gaps_one_done", done_cnt - d0, 32'd1);

        // Abort: sof reappears on payload bit 30 as the first bit of a fresh frame.
        d0 = done_cnt;
        for (int i = 0; i < 29; i++) send_bit(PL[71-i], i == 0, 16'd72, 0);
        send_frame(PL, 72, 16'h29B1, 0);
        check_result("abort", 1'b1, 16'h29B1, 16'h29B1);
        @(negedge clk);
        check("abort_one_done", done_cnt - d0, 32'd1);

        // Reset in the middle of the CRC field.
        for (int i = 0; i < 77; i++) begin
            send_bit((i < 72) ? PL[71-i] : 1'b0, i == 0, 16'd72, 0);
        end
        check("midcrc_calc", {16'd0, crc_calc}, 32'h000029B1);
        check("midcrc_busy", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_calc", {16'd0, crc_calc}, 32'h0000FFFF);
        check("arst_rx", {16'd0, crc_rx}, 32'h0);
`ifdef SERIAL_CRC_CHECK_ERRCNT_EN
        check("arst_errcnt", {16'd0, err_count}, 32'd0);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        send_frame(PL, 72, 16'h29B1, 0);
        check_result("post_rst", 1'b1, 16'h29B1, 16'h29B1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
